// File: rtl/demux_router_if.sv
// rtl/demux_router_if.sv - handshake bundle between a producer and the demux router
interface demux_router_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8
);
  localparam int SEL_W = $clog2(N_OUT);

  logic              enable;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic              in_bcast;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic [N_OUT-1:0]  out_valid;
  logic [N_OUT-1:0]  out_ready;
  logic              busy;
  logic              sel_err;

  modport master (
    output enable, in_valid, in_sel, in_bcast, in_data, out_ready,
    input  in_ready, out_data, out_valid, busy, sel_err
  );

  modport slave (
    input  enable, in_valid, in_sel, in_bcast, in_data, out_ready,
    output in_ready, out_data, out_valid, busy, sel_err
  );
endinterface

// File: rtl/demux_router.sv
// rtl/demux_router.sv - one-word demux to N_OUT channels; broadcast under DEMUX_ROUTER_BCAST_EN
module demux_router #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8
) (
  input  logic            clk,
  input  logic            rst,
  demux_router_if.slave   bus
);
  localparam int SEL_W = $clog2(N_OUT);
  localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [N_OUT-1:0]  pending;
  logic [DATA_W-1:0] word;
  logic              err_q;

  logic [N_OUT-1:0]  remaining;
  logic [N_OUT-1:0]  sel_onehot;
  logic              is_bcast;
  logic              bad_sel;
  logic              in_ready_c;
  logic              xfer;

`ifdef DEMUX_ROUTER_BCAST_EN
  assign is_bcast = bus.in_bcast;
`else
  assign is_bcast = 1'b0 & bus.in_bcast;
`endif

  // A new word may enter in the same cycle the last pending channel drains
  always_comb begin
    remaining  = pending & ~bus.out_ready;
    in_ready_c = bus.enable & ~rst & ((state == IDLE) | (remaining == '0));
    sel_onehot = {{(N_OUT-1){1'b0}}, 1'b1} << bus.in_sel;
    bad_sel    = ~is_bcast & ({1'b0, bus.in_sel} >= N_OUT_L);
    xfer       = bus.in_valid & in_ready_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      word    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= xfer & bad_sel;
      if (xfer && !bad_sel) begin
        word    <= bus.in_data;
        pending <= is_bcast ? '1 : sel_onehot;
        state   <= HOLD;
      end else begin
        pending <= remaining;
        state   <= (remaining == '0) ? IDLE : HOLD;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = pending;
  assign bus.out_data  = word;
  assign bus.busy      = (state == HOLD);
  assign bus.sel_err   = err_q;
endmodule
